// File: rtl/led_pkg.sv
// Shared definitions for the LED matrix driver.
//   fw_state_t          : frame_writer control states
//   FRAME_WORDS_DEFAULT : pixels per frame (64x64 panel)
//   NUM_BUFFERS         : depth of the triple buffer
//   WEA_RGB             : byte enables for a {pad, R, G, B} word
package led_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    DROP   = 2'd2,
    COMMIT = 2'd3
  } fw_state_t;

  localparam int unsigned FRAME_WORDS_DEFAULT = 4096;
  localparam int unsigned NUM_BUFFERS         = 3;
  localparam logic [3:0]  WEA_RGB             = 4'b0111;

endpackage

// File: rtl/frame_writer.sv
// frame_writer: accepts a stream of 24-bit RGB pixels and writes them, one
// 32-bit word per pixel, into the write port of the triple buffer. The write
// buffer select rotates 0->1->2->0 only after a complete, well-formed frame;
// malformed frames are abandoned in place and their buffer is reused.
//
// Ports:
//   clk, resetn             : clock, synchronous active-low reset
//   s_tdata/tvalid/tready   : pixel stream {R,G,B}
//   s_tuser / s_tlast       : start-of-frame / end-of-frame markers
//   din, wraddr, wea, wr    : triple-buffer write port (registered)
//   buffer_sel              : buffer currently being written (0..2)
//   frame_done / frame_err  : one-cycle commit / abort pulses
//   frame_count             : committed frames, wraps at 2^16
module frame_writer
  import led_pkg::*;
#(
  parameter int unsigned FRAME_WORDS = FRAME_WORDS_DEFAULT,
  parameter int unsigned AW          = 12
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [23:0]   s_tdata,
  input  logic          s_tvalid,
  output logic          s_tready,
  input  logic          s_tuser,
  input  logic          s_tlast,
  output logic [31:0]   din,
  output logic [AW-1:0] wraddr,
  output logic [3:0]    wea,
  output logic          wr,
  output logic [1:0]    buffer_sel,
  output logic          frame_done,
  output logic          frame_err,
  output logic [15:0]   frame_count
);

  localparam logic [AW:0] LAST_IDX = (AW+1)'(FRAME_WORDS - 1);
  localparam logic [1:0]  SEL_MAX  = 2'(NUM_BUFFERS - 1);

  fw_state_t     r_state;
  logic [AW:0]   r_cnt;
  logic          r_tready;
  logic [31:0]   r_din;
  logic [AW-1:0] r_wraddr;
  logic [3:0]    r_wea;
  logic          r_wr;
  logic [1:0]    r_sel;
  logic          r_done;
  logic          r_err;
  logic [15:0]   r_count;

  logic          w_accept;
  logic [1:0]    w_sel_next;

  assign w_accept = s_tvalid && r_tready;

  always_comb begin
    w_sel_next = (r_sel == SEL_MAX) ? 2'd0 : r_sel + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_tready <= 1'b0;
      r_din    <= '0;
      r_wraddr <= '0;
      r_wea    <= '0;
      r_wr     <= 1'b0;
      r_sel    <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_count  <= '0;
    end else begin
      // Strobes default low; ready is only withheld for the commit cycle.
      r_wr     <= 1'b0;
      r_wea    <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_tready <= 1'b1;
      case (r_state)
        IDLE, DROP: begin
          if (w_accept) begin
            if (s_tuser) begin
              r_din    <= {8'h00, s_tdata};
              r_wraddr <= '0;
              r_wr     <= 1'b1;
              r_wea    <= WEA_RGB;
              r_cnt    <= (AW+1)'(1);
              r_state  <= WRITE;
            end else if (r_state == DROP && s_tlast) begin
              r_state <= IDLE;
            end
          end
        end
        WRITE: begin
          if (w_accept) begin
            if (s_tuser) begin
              // Restart: the new SOF pixel opens a fresh frame at address 0.
              r_err    <= 1'b1;
              r_din    <= {8'h00, s_tdata};
              r_wraddr <= '0;
              r_wr     <= 1'b1;
              r_wea    <= WEA_RGB;
              r_cnt    <= (AW+1)'(1);
            end else if (s_tlast) begin
              r_din    <= {8'h00, s_tdata};
              r_wraddr <= r_cnt[AW-1:0];
              r_wr     <= 1'b1;
              r_wea    <= WEA_RGB;
              if (r_cnt == LAST_IDX) begin
                r_cnt    <= r_cnt + 1'b1;
                r_tready <= 1'b0;
                r_state  <= COMMIT;
              end else begin
                r_err   <= 1'b1;
                r_cnt   <= '0;
                r_state <= IDLE;
              end
            end else if (r_cnt == LAST_IDX) begin
              // Final slot reached without tlast: this beat is not written.
              r_err   <= 1'b1;
              r_cnt   <= '0;
              r_state <= DROP;
            end else begin
              r_din    <= {8'h00, s_tdata};
              r_wraddr <= r_cnt[AW-1:0];
              r_wr     <= 1'b1;
              r_wea    <= WEA_RGB;
              r_cnt    <= r_cnt + 1'b1;
            end
          end
        end
        COMMIT: begin
          r_sel   <= w_sel_next;
          r_done  <= 1'b1;
          r_count <= r_count + 16'd1;
          r_cnt   <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s_tready    = r_tready;
  assign din         = r_din;
  assign wraddr      = r_wraddr;
  assign wea         = r_wea;
  assign wr          = r_wr;
  assign buffer_sel  = r_sel;
  assign frame_done  = r_done;
  assign frame_err   = r_err;
  assign frame_count = r_count;

endmodule

// File: tb/tb_frame_writer.sv
// Directed bench for frame_writer with FRAME_WORDS=16, AW=4.
module tb_frame_writer;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [23:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tuser = 1'b0;
  logic        s_tlast = 1'b0;
  logic [31:0] din;
  logic [3:0]  wraddr;
  logic [3:0]  wea;
  logic        wr;
  logic [1:0]  buffer_sel;
  logic        frame_done;
  logic        frame_err;
  logic [15:0] frame_count;

  int n_run  = 0;
  int n_fail = 0;

  frame_writer #(.FRAME_WORDS(16), .AW(4)) dut (
    .clk(clk), .resetn(resetn),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tuser(s_tuser), .s_tlast(s_tlast),
    .din(din), .wraddr(wraddr), .wea(wea), .wr(wr),
    .buffer_sel(buffer_sel), .frame_done(frame_done), .frame_err(frame_err),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  // Passive recorder, sampled mid-cycle.
  logic [3:0]  wq_addr[$];
  logic [31:0] wq_data[$];
  logic [1:0]  sel_q[$];
  int n_done, n_err, n_notready, n_badwea, n_sel3;

  always @(negedge clk) begin
    if (wr) begin
      wq_addr.push_back(wraddr);
      wq_data.push_back(din);
      if (wea !== 4'b0111) n_badwea++;
    end else if (wea !== 4'b0000) n_badwea++;
    if (frame_done) begin n_done++; sel_q.push_back(buffer_sel); end
    if (frame_err) n_err++;
    if (resetn && !s_tready) n_notready++;
    if (buffer_sel === 2'd3) n_sel3++;
  end

  task automatic clear_mon();
    wq_addr.delete(); wq_data.delete(); sel_q.delete();
    n_done = 0; n_err = 0; n_notready = 0; n_badwea = 0; n_sel3 = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0; s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  // Present one beat, optionally after idle gap cycles; returns #1 after the
  // accepting edge.
  task automatic beat(input logic [23:0] d, input logic u, input logic l, input int gap);
    int guard;
    guard = 0;
    for (int g = 0; g < gap; g++) @(negedge clk);
    @(negedge clk);
    s_tdata = d; s_tuser = u; s_tlast = l; s_tvalid = 1'b1;
    while (!s_tready && guard < 50) begin @(negedge clk); guard++; end
    if (guard >= 50) begin
      n_run++; n_fail++;
      $display("FAIL beat_ready_timeout: s_tready stuck at %0b, required 1", s_tready);
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk); resetn = 1'b0;
    repeat (2) @(posedge clk); #1;
    n_run++;
    if ({s_tready, wr, wea, frame_done, frame_err} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_ctrl: {tready,wr,wea,done,err}=%0h, required 0", {s_tready, wr, wea, frame_done, frame_err});
    end
    n_run++;
    if ({din, wraddr, buffer_sel, frame_count} !== 54'h0) begin
      n_fail++;
      $display("FAIL reset_data: din=%0h wraddr=%0h sel=%0d count=%0d, required all 0", din, wraddr, buffer_sel, frame_count);
    end
    do_reset();
    n_run++;
    if (s_tready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %0b, required 1", s_tready); end
  endtask

  task automatic test_clean_frame();
    int bad;
    logic [23:0] px;
    do_reset(); clear_mon();
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      px = 24'hA00000 + 24'(i * 24'h010203);
      beat(px, i == 0, i == 15, 0);
      if (wr !== 1'b1 || wraddr !== 4'(i) || din !== {8'h00, px} || wea !== 4'b0111) bad++;
    end
    n_run++;
    if (bad != 0) begin n_fail++; $display("FAIL clean_write_latency: %0d bad beats, required 0", bad); end
    n_run++;
    if (s_tready !== 1'b0 || frame_done !== 1'b0) begin
      n_fail++; $display("FAIL clean_commit_bubble: tready=%0b done=%0b, required 0 0", s_tready, frame_done);
    end
    @(posedge clk); #1;
    n_run++;
    if ({frame_done, buffer_sel, frame_count, s_tready} !== {1'b1, 2'd1, 16'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL clean_commit: done=%0b sel=%0d count=%0d tready=%0b, required 1 1 1 1", frame_done, buffer_sel, frame_count, s_tready);
    end
    idle(3);
    n_run++;
    if (n_done != 1 || n_notready != 1 || n_err != 0 || n_badwea != 0 || wq_addr.size() != 16) begin
      n_fail++;
      $display("FAIL clean_totals: done=%0d notready=%0d err=%0d badwea=%0d writes=%0d, required 1 1 0 0 16", n_done, n_notready, n_err, n_badwea, wq_addr.size());
    end
  endtask

  task automatic test_rotation();
    logic [1:0] exp_sel [4];
    int bad;
    exp_sel = '{2'd1, 2'd2, 2'd0, 2'd1};
    do_reset(); clear_mon();
    for (int f = 0; f < 4; f++)
      for (int i = 0; i < 16; i++) beat(24'(f * 256 + i), i == 0, i == 15, 0);
    idle(3);
    bad = 0;
    n_run++;
    if (sel_q.size() != 4) begin
      n_fail++; $display("FAIL rot_done_count: got %0d, required 4", sel_q.size());
    end else begin
      for (int k = 0; k < 4; k++) if (sel_q[k] !== exp_sel[k]) bad++;
      if (bad != 0) begin n_fail++; $display("FAIL rot_sequence: %0d wrong, required sequence 1 2 0 1", bad); end
    end
    n_run++;
    if (frame_count !== 16'd4 || n_sel3 != 0) begin
      n_fail++; $display("FAIL rot_count: count=%0d sel3=%0d, required 4 0", frame_count, n_sel3);
    end
  endtask

  task automatic test_early_last();
    do_reset(); clear_mon();
    for (int i = 0; i < 10; i++) begin
      beat(24'h111100 + 24'(i), i == 0, i == 9, 0);
    end
    n_run++;
    if (frame_err !== 1'b1 || wraddr !== 4'd9 || s_tready !== 1'b1) begin
      n_fail++; $display("FAIL early_err_pulse: err=%0b addr=%0d tready=%0b, required 1 9 1", frame_err, wraddr, s_tready);
    end
    idle(3);
    n_run++;
    if (wq_addr.size() != 10 || n_err != 1 || n_done != 0 || buffer_sel !== 2'd0) begin
      n_fail++;
      $display("FAIL early_totals: writes=%0d err=%0d done=%0d sel=%0d, required 10 1 0 0", wq_addr.size(), n_err, n_done, buffer_sel);
    end
  endtask

  task automatic test_missing_last();
    int bad;
    do_reset(); clear_mon();
    for (int i = 0; i < 20; i++) begin
      beat(24'h220000 + 24'(i), i == 0, i == 19, 0);
      if (i == 15) begin
        n_run++;
        if (frame_err !== 1'b1 || wr !== 1'b0) begin
          n_fail++; $display("FAIL missing_err_pulse: err=%0b wr=%0b, required 1 0", frame_err, wr);
        end
      end
    end
    idle(3);
    bad = 0;
    for (int k = 0; k < wq_addr.size(); k++)
      if (wq_addr[k] !== 4'(k) || wq_data[k] !== {8'h22, 16'h0000, 8'(k)} - 32'h22000000 + 32'h00220000) bad++;
    n_run++;
    if (wq_addr.size() != 15 || bad != 0 || n_err != 1 || n_done != 0 || buffer_sel !== 2'd0) begin
      n_fail++;
      $display("FAIL missing_totals: writes=%0d bad=%0d err=%0d done=%0d sel=%0d, required 15 0 1 0 0", wq_addr.size(), bad, n_err, n_done, buffer_sel);
    end
  endtask

  task automatic test_mid_sof();
    do_reset(); clear_mon();
    for (int i = 0; i < 22; i++) begin
      beat(24'h330000 + 24'(i), i == 0 || i == 6, i == 21, 0);
      if (i == 6) begin
        n_run++;
        if (frame_err !== 1'b1 || wr !== 1'b1 || wraddr !== 4'd0 || din !== 32'h00330006) begin
          n_fail++; $display("FAIL sof_restart: err=%0b wr=%0b addr=%0d din=%0h, required 1 1 0 330006", frame_err, wr, wraddr, din);
        end
      end
    end
    idle(3);
    n_run++;
    if (wq_addr.size() != 22 || wq_addr[21] !== 4'd15 || wq_data[21] !== 32'h00330015 || n_err != 1 || n_done != 1 || buffer_sel !== 2'd1) begin
      n_fail++;
      $display("FAIL sof_totals: writes=%0d err=%0d done=%0d sel=%0d, required 22 1 1 1", wq_addr.size(), n_err, n_done, buffer_sel);
    end
  endtask

  task automatic test_gaps_and_reset();
    int bad;
    do_reset(); clear_mon();
    for (int i = 0; i < 16; i++) beat(24'h440000 + 24'(i), i == 0, i == 15, $urandom_range(0, 2));
    idle(3);
    bad = 0;
    for (int k = 0; k < wq_addr.size(); k++)
      if (wq_addr[k] !== 4'(k) || wq_data[k] !== 32'h00440000 + 32'(k)) bad++;
    n_run++;
    if (wq_addr.size() != 16 || bad != 0 || n_done != 1 || frame_count !== 16'd1) begin
      n_fail++; $display("FAIL gaps_contiguous: writes=%0d bad=%0d done=%0d count=%0d, required 16 0 1 1", wq_addr.size(), bad, n_done, frame_count);
    end
    for (int i = 0; i < 8; i++) beat(24'h550000 + 24'(i), i == 0, 1'b0, 0);
    @(negedge clk);
    resetn = 1'b0; s_tvalid = 1'b1; s_tdata = 24'h550008;
    @(posedge clk); #1;
    n_run++;
    if ({wr, buffer_sel, frame_count, s_tready} !== 20'h0) begin
      n_fail++; $display("FAIL midreset: wr=%0b sel=%0d count=%0d tready=%0b, required 0 0 0 0", wr, buffer_sel, frame_count, s_tready);
    end
    s_tvalid = 1'b0;
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
    clear_mon();
    beat(24'h660000, 1'b0, 1'b0, 0);
    idle(2);
    n_run++;
    if (wq_addr.size() != 0) begin
      n_fail++; $display("FAIL midreset_idle: writes=%0d after non-SOF beat, required 0", wq_addr.size());
    end
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_rotation();
    test_early_last();
    test_missing_last();
    test_mid_sof();
    test_gaps_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/frame_writer.md
# frame_writer

Upstream stage of the LED matrix driver. It accepts a stream of 24-bit RGB pixels and writes each pixel as one 32-bit word into the triple buffer's write port (`din`, `wraddr`, `wea`, `wr`). It owns the 2-bit `buffer_sel` that chooses which of the three buffers is being written, and rotates it only after a complete, well-formed frame. Malformed frames are dropped, so the display side never sees a partial frame.

## Interface
Parameters:
- `FRAME_WORDS`, default 4096: pixels per frame; must be ≤ 4096.
- `AW`, default 12: write address width.

Ports:
- `clk` in 1: single clock (100 MHz system clock); all logic is on its rising edge.
- `resetn` in 1: reset, synchronous, active-low.
- `s_tdata` in 24: pixel `{R[23:16], G[15:8], B[7:0]}`.
- `s_tvalid` in 1: pixel valid.
- `s_tready` out 1: writer can accept a pixel.
- `s_tuser` in 1: start-of-frame; marks the first pixel of a frame.
- `s_tlast` in 1: marks the last pixel of a frame.
- `din` out 32: `{8'h00, s_tdata}`.
- `wraddr` out AW: word address, 0..FRAME_WORDS-1.
- `wea` out 4: byte enables; `4'b0111` whenever `wr`=1, else `4'b0000`.
- `wr` out 1: write strobe, one cycle per word.
- `buffer_sel` out 2: current write buffer, one of 0, 1, 2; value 3 is never driven.
- `frame_done` out 1: one-cycle pulse when a frame is committed.
- `frame_err` out 1: one-cycle pulse when a frame is aborted.
- `frame_count` out 16: count of committed frames; wraps.

## Operation
- A beat is accepted when `s_tvalid && s_tready`. All outputs are registered.
- **Reset values:** `s_tready`=0, `din`=0, `wraddr`=0, `wea`=0, `wr`=0, `buffer_sel`=0, `frame_done`=0, `frame_err`=0, `frame_count`=0, state = IDLE, pixel counter `cnt`=0.
- **IDLE** (`s_tready`=1):
  - Beat with `s_tuser`=1: write the pixel at address 0, set `cnt`=1, go to WRITE.
  - Beat with `s_tuser`=0: discard it, no write, stay in IDLE.
- **WRITE** (`s_tready`=1). Each beat writes at address `cnt`, then `cnt`++.
  - `s_tuser`=1 mid-frame: pulse `frame_err`, write this pixel at address 0, set `cnt`=1, stay in WRITE (restart).
  - `s_tlast`=1 with `cnt`==FRAME_WORDS-1: write the pixel, go to COMMIT.
  - `s_tlast`=1 with `cnt`<FRAME_WORDS-1 (early last): write the pixel, pulse `frame_err`, go to IDLE. `buffer_sel` is unchanged.
  - `cnt`==FRAME_WORDS-1 with `s_tlast`=0 (missing last): do not write, pulse `frame_err`, go to DROP.
- **DROP** (`s_tready`=1): discard beats until one with `s_tlast`=1, then go to IDLE. A beat with `s_tuser`=1 arriving in DROP is treated exactly as in IDLE.
- **COMMIT** (`s_tready`=0, exactly one cycle):
  - `buffer_sel` advances 0→1→2→0.
  - Pulse `frame_done`; `frame_count`++.
  - Go to IDLE.
- **Width rules:** `cnt` is AW+1 bits and never exceeds FRAME_WORDS. `frame_count` wraps modulo 2^16.
- **Errored frames:** the partially written buffer is left as-is and is reused by the next frame, because `buffer_sel` did not move.

## Timing
- Write latency is 1 cycle: a beat accepted on edge N drives `wr`=1 with matching `din`/`wraddr` during cycle N+1.
- Back-to-back beats give one write per cycle.
- `buffer_sel` changes and `frame_done` pulses on the edge after the final write's cycle. Both are visible in the same cycle.
- `frame_err` pulses in the cycle after the offending beat is accepted.
- `s_tready` is 0 in the cycle after a last beat is accepted (the COMMIT bubble). Minimum frame period is FRAME_WORDS+1 cycles.
- Reset asserted mid-frame: on the next edge all outputs take their reset values, and any in-flight write is suppressed (`wr`=0).

## Structure
- Shared package `led_pkg` holds:
  - the `fw_state_t` enum: IDLE, WRITE, DROP, COMMIT;
  - `FRAME_WORDS_DEFAULT` = 4096;
  - `NUM_BUFFERS` = 3;
  - the `WEA_RGB` = `4'b0111` constant.
- Single module, no sub-modules; the buffer rotation is a 2-bit modulo-3 counter written inline.

## Test plan
- **Clean frame:** FRAME_WORDS=16, 16 beats, `s_tuser` on beat 0, `s_tlast` on beat 15, `s_tvalid` held high → 16 writes at addresses 0..15, `din`=`{8'h00, pixel}`, `wea`=0111; then `buffer_sel` 0→1, one `frame_done`, `frame_count`=1, `s_tready` low for 1 cycle.
- **Rotation:** 4 clean frames → `buffer_sel` sequence 1, 2, 0, 1; `frame_count`=4; value 3 never appears.
- **Early last:** `s_tlast` on beat 9 → 10 writes, one `frame_err`, `buffer_sel` unchanged, no `frame_done`.
- **Missing last:** 20 beats with `s_tlast` only on beat 19 → writes at addresses 0..14, then `frame_err`, beats 15..19 dropped, no commit.
- **Mid-frame SOF:** `s_tuser` on beat 6 → `frame_err` pulse, beat 6 written at address 0, frame continues and commits after 16 beats counted from beat 6.
- **Reset and gaps:** `s_tvalid` toggled randomly → addresses stay contiguous with no duplicate writes. `resetn`=0 at beat 8 → next cycle `wr`=0, `buffer_sel`=0, `frame_count`=0, state IDLE.
